// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//   Bundles the reservation-station issue port and the CDB broadcast port of
//   the ALU execution unit.
//
//   Issue side (driven by the issuer / master):
//     issue_op      7      opcode, 0 = nothing issued this cycle
//     issue_vi      32     rs1 operand value
//     issue_vj      32     rs2 operand value
//     issue_imm     32     sign-extended immediate
//     issue_pc      32     instruction PC
//     issue_rob_id  TAG_W  destination ROB tag
//     cdb_grant     1      CDB arbiter grant for this unit
//   Unit side (driven by the ALU / slave):
//     alu_full      1      issuer must stop issuing while high
//     cdb_req       1      result buffer non-empty
//     alu_valid     1      broadcast valid (cdb_req & cdb_grant)
//     alu_res       32     head result value
//     alu_rob_id    TAG_W  head result tag
//     alu_jump      1      head entry is a taken control transfer
//     alu_target    32     head entry next PC
//     alu_ovf_err   1      sticky overflow (push into full buffer)
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
  parameter int TAG_W = 5
);
  logic [6:0]       issue_op;
  logic [31:0]      issue_vi;
  logic [31:0]      issue_vj;
  logic [31:0]      issue_imm;
  logic [31:0]      issue_pc;
  logic [TAG_W-1:0] issue_rob_id;
  logic             cdb_grant;

  logic             alu_full;
  logic             cdb_req;
  logic             alu_valid;
  logic [31:0]      alu_res;
  logic [TAG_W-1:0] alu_rob_id;
  logic             alu_jump;
  logic [31:0]      alu_target;
  logic             alu_ovf_err;

  modport master (
    output issue_op, issue_vi, issue_vj, issue_imm, issue_pc, issue_rob_id,
    output cdb_grant,
    input  alu_full, cdb_req, alu_valid, alu_res, alu_rob_id,
    input  alu_jump, alu_target, alu_ovf_err
  );

  modport slave (
    input  issue_op, issue_vi, issue_vj, issue_imm, issue_pc, issue_rob_id,
    input  cdb_grant,
    output alu_full, cdb_req, alu_valid, alu_res, alu_rob_id,
    output alu_jump, alu_target, alu_ovf_err
  );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Integer/branch execution unit fed by the reservation-station issue port.
//   Each accepted op is evaluated combinationally and written into a small
//   FIFO result buffer on the same edge; the buffer head is offered on the
//   CDB and retired only when the arbiter grants it, so results are never
//   lost to a missed arbitration cycle.
//
//   Ports:
//     clk           system clock
//     rst           synchronous reset, active low
//     rdy           global clock enable, all state holds while low
//     wrong_commit  misprediction flush from the ROB
//     bus           alu_exec_unit_if.slave (issue port + CDB broadcast)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             wrong_commit,
  alu_exec_unit_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Shared opcode enumeration; 0 means no issue.
  typedef enum logic [6:0] {
    OP_NONE  = 7'd0,
    OP_LUI   = 7'd1,
    OP_AUIPC = 7'd2,
    OP_JAL   = 7'd3,
    OP_JALR  = 7'd4,
    OP_BEQ   = 7'd5,
    OP_BNE   = 7'd6,
    OP_BLT   = 7'd7,
    OP_BGE   = 7'd8,
    OP_BLTU  = 7'd9,
    OP_BGEU  = 7'd10,
    OP_ADDI  = 7'd11,
    OP_SLTI  = 7'd12,
    OP_SLTIU = 7'd13,
    OP_XORI  = 7'd14,
    OP_ORI   = 7'd15,
    OP_ANDI  = 7'd16,
    OP_SLLI  = 7'd17,
    OP_SRLI  = 7'd18,
    OP_SRAI  = 7'd19,
    OP_ADD   = 7'd20,
    OP_SUB   = 7'd21,
    OP_SLL   = 7'd22,
    OP_SLT   = 7'd23,
    OP_SLTU  = 7'd24,
    OP_XOR   = 7'd25,
    OP_SRL   = 7'd26,
    OP_SRA   = 7'd27,
    OP_OR    = 7'd28,
    OP_AND   = 7'd29
  } op_e;

  // Result buffer storage
  logic [31:0]      res_mem    [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic             jump_mem   [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf_err;

  // Combinational execute results
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        is_branch;
  logic        br_take;
  logic [31:0] calc_res;
  logic        calc_jump;
  logic [31:0] calc_target;

  // Buffer control
  logic buf_empty;
  logic buf_full;
  logic push_req;
  logic do_push;
  logic do_pop;

  // Execute stage: I-type ops (ADDI..SRAI) take the immediate as second
  // operand; branches share one comparator result and one target mux.
  always_comb begin
    operand_b   = ((bus.issue_op >= OP_ADDI) && (bus.issue_op <= OP_SRAI))
                  ? bus.issue_imm : bus.issue_vj;
    shamt       = operand_b[4:0];
    pc_plus4    = bus.issue_pc + 32'd4;
    pc_target   = bus.issue_pc + bus.issue_imm;
    is_branch   = 1'b0;
    br_take     = 1'b0;
    calc_res    = 32'd0;
    calc_jump   = 1'b0;
    calc_target = pc_plus4;

    case (bus.issue_op)
      OP_LUI:   calc_res = bus.issue_imm;
      OP_AUIPC: calc_res = pc_target;
      OP_JAL: begin
        calc_res    = pc_plus4;
        calc_jump   = 1'b1;
        calc_target = pc_target;
      end
      OP_JALR: begin
        calc_res    = pc_plus4;
        calc_jump   = 1'b1;
        calc_target = (bus.issue_vi + bus.issue_imm) & ~32'd1;
      end
      OP_BEQ: begin
        is_branch = 1'b1;
        br_take   = (bus.issue_vi == bus.issue_vj);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        br_take   = (bus.issue_vi != bus.issue_vj);
      end
      OP_BLT: begin
        is_branch = 1'b1;
        br_take   = ($signed(bus.issue_vi) < $signed(bus.issue_vj));
      end
      OP_BGE: begin
        is_branch = 1'b1;
        br_take   = ($signed(bus.issue_vi) >= $signed(bus.issue_vj));
      end
      OP_BLTU: begin
        is_branch = 1'b1;
        br_take   = (bus.issue_vi < bus.issue_vj);
      end
      OP_BGEU: begin
        is_branch = 1'b1;
        br_take   = (bus.issue_vi >= bus.issue_vj);
      end
      OP_ADD, OP_ADDI:   calc_res = bus.issue_vi + operand_b;
      OP_SUB:            calc_res = bus.issue_vi - operand_b;
      OP_SLL, OP_SLLI:   calc_res = bus.issue_vi << shamt;
      OP_SLT, OP_SLTI:   calc_res = {31'd0, ($signed(bus.issue_vi) < $signed(operand_b))};
      OP_SLTU, OP_SLTIU: calc_res = {31'd0, (bus.issue_vi < operand_b)};
      OP_XOR, OP_XORI:   calc_res = bus.issue_vi ^ operand_b;
      OP_SRL, OP_SRLI:   calc_res = bus.issue_vi >> shamt;
      OP_SRA, OP_SRAI:   calc_res = $signed(bus.issue_vi) >>> shamt;
      OP_OR, OP_ORI:     calc_res = bus.issue_vi | operand_b;
      OP_AND, OP_ANDI:   calc_res = bus.issue_vi & operand_b;
      default:           calc_res = 32'd0;
    endcase

    if (is_branch) begin
      calc_jump   = br_take;
      calc_target = br_take ? pc_target : pc_plus4;
    end
  end

  // Push/pop decisions. A pop frees a slot on the same edge, so a push into
  // a full buffer is legal when the head is being granted; otherwise it is
  // dropped and flagged. Flush suppresses the push but not the pop.
  always_comb begin
    buf_empty = (count == '0);
    buf_full  = (count == CNT_W'(DEPTH));
    push_req  = rst && rdy && !wrong_commit && (bus.issue_op != OP_NONE);
    do_pop    = rst && rdy && bus.alu_valid;
    do_push   = push_req && (!buf_full || do_pop);
  end

  // Pointer, occupancy and sticky error state. Reset wins over everything;
  // flush empties the buffer and discards any same-cycle issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (rdy) begin
      if (wrong_commit) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
          count <= count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
          count <= count - CNT_W'(1);
        end
        if (push_req && !do_push) begin
          ovf_err <= 1'b1;
        end
      end
    end
  end

  // Result storage. Entries need no reset: outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      res_mem[wr_ptr]    <= calc_res;
      tag_mem[wr_ptr]    <= bus.issue_rob_id;
      jump_mem[wr_ptr]   <= calc_jump;
      target_mem[wr_ptr] <= calc_target;
    end
  end

  // CDB broadcast of the buffer head; all head fields read 0 when empty.
  always_comb begin
    bus.cdb_req     = !buf_empty;
    bus.alu_valid   = !buf_empty && bus.cdb_grant;
    bus.alu_full    = (count >= CNT_W'(DEPTH - 1));
    bus.alu_ovf_err = ovf_err;
    bus.alu_res     = buf_empty ? 32'd0 : res_mem[rd_ptr];
    bus.alu_rob_id  = buf_empty ? '0 : tag_mem[rd_ptr];
    bus.alu_jump    = buf_empty ? 1'b0 : jump_mem[rd_ptr];
    bus.alu_target  = buf_empty ? 32'd0 : target_mem[rd_ptr];
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Self-checking bench for alu_exec_unit. A reference model turns every
//   driven op into an expected CDB entry pushed onto a scoreboard queue; the
//   queue head is compared with the broadcast and popped on each grant.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  localparam logic [6:0] OP_LUI   = 7'd1;
  localparam logic [6:0] OP_AUIPC = 7'd2;
  localparam logic [6:0] OP_JAL   = 7'd3;
  localparam logic [6:0] OP_JALR  = 7'd4;
  localparam logic [6:0] OP_BEQ   = 7'd5;
  localparam logic [6:0] OP_BNE   = 7'd6;
  localparam logic [6:0] OP_BLT   = 7'd7;
  localparam logic [6:0] OP_BGE   = 7'd8;
  localparam logic [6:0] OP_BLTU  = 7'd9;
  localparam logic [6:0] OP_BGEU  = 7'd10;
  localparam logic [6:0] OP_ADDI  = 7'd11;
  localparam logic [6:0] OP_SLTI  = 7'd12;
  localparam logic [6:0] OP_SLTIU = 7'd13;
  localparam logic [6:0] OP_XORI  = 7'd14;
  localparam logic [6:0] OP_ORI   = 7'd15;
  localparam logic [6:0] OP_ANDI  = 7'd16;
  localparam logic [6:0] OP_SLLI  = 7'd17;
  localparam logic [6:0] OP_SRLI  = 7'd18;
  localparam logic [6:0] OP_SRAI  = 7'd19;
  localparam logic [6:0] OP_ADD   = 7'd20;
  localparam logic [6:0] OP_SUB   = 7'd21;
  localparam logic [6:0] OP_SLL   = 7'd22;
  localparam logic [6:0] OP_SLT   = 7'd23;
  localparam logic [6:0] OP_SLTU  = 7'd24;
  localparam logic [6:0] OP_XOR   = 7'd25;
  localparam logic [6:0] OP_SRL   = 7'd26;
  localparam logic [6:0] OP_SRA   = 7'd27;
  localparam logic [6:0] OP_OR    = 7'd28;
  localparam logic [6:0] OP_AND   = 7'd29;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             jump;
    logic [31:0]      target;
  } exp_t;

  logic clk;
  logic rst;
  logic rdy;
  logic wrong_commit;

  alu_exec_unit_if #(.TAG_W(TAG_W)) bus ();

  alu_exec_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .wrong_commit (wrong_commit),
    .bus          (bus.slave)
  );

  exp_t exp_q[$];
  logic m_ovf;
  bit   checks_on;
  int   total_checks;
  int   passed_checks;

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of one execute operation
  function automatic exp_t ref_calc(input logic [6:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] imm,
                                    input logic [31:0] pc, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic t;
    logic br;
    seq_pc   = pc + 32'd4;
    br_pc    = pc + imm;
    t        = 1'b0;
    br       = 1'b0;
    e.tag    = tag;
    e.res    = 32'd0;
    e.jump   = 1'b0;
    e.target = seq_pc;
    case (op)
      OP_LUI:   e.res = imm;
      OP_AUIPC: e.res = pc + imm;
      OP_JAL:   begin e.res = seq_pc; e.jump = 1'b1; e.target = br_pc; end
      OP_JALR:  begin e.res = seq_pc; e.jump = 1'b1; e.target = {a[31:1] + imm[31:1] + {30'd0, a[0] & imm[0]}, 1'b0}; end
      OP_BEQ:   begin br = 1'b1; t = (a == b); end
      OP_BNE:   begin br = 1'b1; t = (a != b); end
      OP_BLT:   begin br = 1'b1; t = ($signed(a) < $signed(b)); end
      OP_BGE:   begin br = 1'b1; t = !($signed(a) < $signed(b)); end
      OP_BLTU:  begin br = 1'b1; t = (a < b); end
      OP_BGEU:  begin br = 1'b1; t = !(a < b); end
      OP_ADDI:  e.res = a + imm;
      OP_SLTI:  e.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      OP_SLTIU: e.res = (a < imm) ? 32'd1 : 32'd0;
      OP_XORI:  e.res = a ^ imm;
      OP_ORI:   e.res = a | imm;
      OP_ANDI:  e.res = a & imm;
      OP_SLLI:  e.res = a << imm[4:0];
      OP_SRLI:  e.res = a >> imm[4:0];
      OP_SRAI:  e.res = $signed(a) >>> imm[4:0];
      OP_ADD:   e.res = a + b;
      OP_SUB:   e.res = a - b;
      OP_SLL:   e.res = a << b[4:0];
      OP_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:   e.res = a ^ b;
      OP_SRL:   e.res = a >> b[4:0];
      OP_SRA:   e.res = $signed(a) >>> b[4:0];
      OP_OR:    e.res = a | b;
      OP_AND:   e.res = a & b;
      default:  e.res = 32'd0;
    endcase
    if (br) begin
      e.jump   = t;
      e.target = t ? br_pc : seq_pc;
    end
    return e;
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_checks++;
    if (got === want) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // One clock cycle: compare current outputs with the scoreboard, then update
  // the model the way the coming posedge should update the DUT.
  task automatic tick();
    exp_t head;
    bit   pop;
    bit   was_full;
    #1;
    if (checks_on) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      checkOutput("cdb_req",    {31'd0, bus.cdb_req},    {31'd0, exp_q.size() != 0});
      checkOutput("alu_valid",  {31'd0, bus.alu_valid},  {31'd0, (exp_q.size() != 0) && bus.cdb_grant});
      checkOutput("alu_full",   {31'd0, bus.alu_full},   {31'd0, exp_q.size() >= DEPTH - 1});
      checkOutput("ovf_err",    {31'd0, bus.alu_ovf_err}, {31'd0, m_ovf});
      checkOutput("alu_res",    bus.alu_res,             head.res);
      checkOutput("alu_rob_id", {27'd0, bus.alu_rob_id}, {27'd0, head.tag});
      checkOutput("alu_jump",   {31'd0, bus.alu_jump},   {31'd0, head.jump});
      checkOutput("alu_target", bus.alu_target,          head.target);
    end
    if (!rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
    end else if (rdy) begin
      pop      = (exp_q.size() != 0) && bus.cdb_grant;
      was_full = (exp_q.size() == DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (wrong_commit) begin
        exp_q.delete();
      end else if (bus.issue_op != 7'd0) begin
        if (was_full && !pop) m_ovf = 1'b1;
        else exp_q.push_back(ref_calc(bus.issue_op, bus.issue_vi, bus.issue_vj,
                                      bus.issue_imm, bus.issue_pc, bus.issue_rob_id));
      end
    end
    @(negedge clk);
  endtask

  // Drive one issue for a cycle, then return the issue port to idle
  task automatic applyStimulus(input logic [6:0] op, input logic [31:0] vi, input logic [31:0] vj,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [TAG_W-1:0] tag);
    bus.issue_op     = op;
    bus.issue_vi     = vi;
    bus.issue_vj     = vj;
    bus.issue_imm    = imm;
    bus.issue_pc     = pc;
    bus.issue_rob_id = tag;
    tick();
    bus.issue_op     = 7'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total_checks      = 0;
    passed_checks     = 0;
    checks_on         = 1'b0;
    m_ovf             = 1'b0;
    rst               = 1'b0;
    rdy               = 1'b1;
    wrong_commit      = 1'b0;
    bus.issue_op      = 7'd0;
    bus.issue_vi      = 32'd0;
    bus.issue_vj      = 32'd0;
    bus.issue_imm     = 32'd0;
    bus.issue_pc      = 32'd0;
    bus.issue_rob_id  = '0;
    bus.cdb_grant     = 1'b0;
    @(negedge clk);
    idle(2);
    rst       = 1'b1;
    checks_on = 1'b1;
    idle(1);

    // Basic ops with grant held high, one result in flight at a time
    bus.cdb_grant = 1'b1;
    applyStimulus(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h0000_0200, 5'd3);
    #1 checkOutput("add_res", bus.alu_res, 32'd12);
    checkOutput("add_tag", {27'd0, bus.alu_rob_id}, 32'd3);
    checkOutput("add_target", bus.alu_target, 32'h0000_0204);
    idle(2);
    applyStimulus(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd4);
    #1 checkOutput("blt_jump", {31'd0, bus.alu_jump}, 32'd1);
    checkOutput("blt_target", bus.alu_target, 32'h120);
    checkOutput("blt_res", bus.alu_res, 32'd0);
    applyStimulus(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5);
    #1 checkOutput("bltu_jump", {31'd0, bus.alu_jump}, 32'd0);
    checkOutput("bltu_target", bus.alu_target, 32'h104);
    applyStimulus(OP_JALR, 32'h1003, 32'd0, 32'd4, 32'h40, 5'd6);
    #1 checkOutput("jalr_res", bus.alu_res, 32'h44);
    checkOutput("jalr_target", bus.alu_target, 32'h1006);
    applyStimulus(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h80, 5'd7);
    #1 checkOutput("srai_res", bus.alu_res, 32'hF800_0000);
    idle(2);

    // Back-pressure: three results held, then drained in order
    bus.cdb_grant = 1'b0;
    applyStimulus(OP_ADDI, 32'd10, 32'd0, 32'd1, 32'h300, 5'd1);
    applyStimulus(OP_ADDI, 32'd20, 32'd0, 32'd2, 32'h304, 5'd2);
    applyStimulus(OP_ADDI, 32'd30, 32'd0, 32'd3, 32'h308, 5'd3);
    #1 checkOutput("full_at_3", {31'd0, bus.alu_full}, 32'd1);
    bus.cdb_grant = 1'b1;
    idle(1);
    #1 checkOutput("full_after_pop", {31'd0, bus.alu_full}, 32'd0);
    checkOutput("drain_tag2", {27'd0, bus.alu_rob_id}, 32'd2);
    idle(3);

    // Flush with a same-cycle issue
    bus.cdb_grant = 1'b0;
    applyStimulus(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'h400, 5'd8);
    applyStimulus(OP_AUIPC, 32'd0, 32'd0, 32'h0000_1000, 32'h404, 5'd9);
    wrong_commit = 1'b1;
    applyStimulus(OP_JAL, 32'd0, 32'd0, 32'h80, 32'h408, 5'd10);
    wrong_commit = 1'b0;
    #1 checkOutput("flush_req", {31'd0, bus.cdb_req}, 32'd0);
    bus.cdb_grant = 1'b1;
    applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'h500, 5'd11);
    #1 checkOutput("post_flush_tag", {27'd0, bus.alu_rob_id}, 32'd11);
    idle(2);

    // Overflow, push+pop at full, rdy stall, then reset mid-stream
    bus.cdb_grant = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(OP_SUB, 32'd100, 32'(i), 32'd0, 32'h600 + 32'(4 * i), TAG_W'(12 + i));
    end
    applyStimulus(OP_OR, 32'd1, 32'd2, 32'd0, 32'h700, 5'd20);
    #1 checkOutput("ovf_set", {31'd0, bus.alu_ovf_err}, 32'd1);
    checkOutput("ovf_head_tag", {27'd0, bus.alu_rob_id}, 32'd12);
    bus.cdb_grant = 1'b1;
    applyStimulus(OP_AND, 32'hFF, 32'h0F, 32'd0, 32'h704, 5'd21);
    rdy = 1'b0;
    applyStimulus(OP_SLL, 32'd1, 32'd4, 32'd0, 32'h708, 5'd22);
    rdy = 1'b1;
    bus.cdb_grant = 1'b0;
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    #1 checkOutput("rst_req", {31'd0, bus.cdb_req}, 32'd0);
    checkOutput("rst_ovf", {31'd0, bus.alu_ovf_err}, 32'd0);
    idle(1);

    // Randomised traffic honouring alu_full, with stalls and rare flushes
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  op;
      logic [31:0] vi;
      logic [31:0] vj;
      rdy           = ($urandom_range(0, 7) != 0);
      bus.cdb_grant = ($urandom_range(0, 2) != 0);
      wrong_commit  = ($urandom_range(0, 40) == 0);
      op = (exp_q.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) ? 7'($urandom_range(1, 30)) : 7'd0;
      vi = $urandom();
      vj = ($urandom_range(0, 3) == 0) ? vi : $urandom();
      applyStimulus(op, vi, vj, 32'($signed(12'($urandom()))), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    TAG_W'($urandom_range(1, 31)));
    end
    wrong_commit  = 1'b0;
    rdy           = 1'b1;
    bus.cdb_grant = 1'b1;
    idle(DEPTH + 2);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the reservation-station issue port.
- Each cycle it takes at most one ready operation (op, Vi, Vj, imm, pc, ROB tag) and computes the integer/branch result.
- Results are queued in a small result buffer and broadcast on the common data bus (CDB) under an external grant, so a lost arbitration cycle never drops a result.
- Drives the alu_valid/alu_res/alu_rob_id broadcast consumed by the RS, the ROB and the LSB.

Parameters:
- DEPTH, 4, result-buffer entries; power of two, at least 2.
- TAG_W, 5, ROB tag width; tag 0 means "no producer", so valid tags are 1-based.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset (0 = reset).
- rdy  in  1  global clock enable; when 0 all state holds.
- wrong_commit  in  1  misprediction flush from the ROB.
- issue_op  in  7  operation from the shared opcode enumeration; 0 = no issue this cycle.
- issue_vi  in  32  operand rs1 value.
- issue_vj  in  32  operand rs2 value.
- issue_imm  in  32  sign-extended immediate.
- issue_pc  in  32  instruction PC.
- issue_rob_id  in  TAG_W  destination ROB tag.
- alu_full  out  1  asserted when count >= DEPTH-1; the issuer must not issue while it is high.
- cdb_req  out  1  buffer non-empty; this unit requests the CDB.
- cdb_grant  in  1  CDB arbiter grant for this cycle.
- alu_valid  out  1  broadcast valid, equal to cdb_req AND cdb_grant.
- alu_res  out  32  head result value.
- alu_rob_id  out  TAG_W  head result tag.
- alu_jump  out  1  head entry: control transfer taken (JAL, JALR, taken branch).
- alu_target  out  32  head entry: next PC (target when taken, pc+4 otherwise).
- alu_ovf_err  out  1  sticky flag, set on a push into a full buffer.

Behaviour:
- Reset (rst=0 at posedge): count=0, read/write pointers=0, alu_ovf_err=0. With the buffer empty, alu_valid, cdb_req, alu_res, alu_rob_id, alu_jump and alu_target all read 0; alu_full=0.
- rdy=0: no push, no pop, no flag updates. Outputs keep reflecting current state.
- Issue: an op is accepted when issue_op != 0 at a posedge with rdy=1.
  - Its result is computed combinationally from the issue inputs and written to the tail at that same edge.
  - It can be broadcast the next cycle at the earliest (1-cycle latency).
- Arithmetic, all modulo 2^32:
  - I-type ops use issue_imm in place of Vj.
  - Shift amount is operand[4:0]. SRA/SRAI shift arithmetically. SLT/SLTI compare signed; SLTU/SLTIU compare unsigned and return 0 or 1.
  - LUI: res = imm. AUIPC: res = pc + imm.
  - JAL: res = pc+4, jump=1, target = pc+imm.
  - JALR: res = pc+4, jump=1, target = (Vi+imm) & ~1.
  - Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU): res = 0, jump = condition, target = condition ? pc+imm : pc+4.
  - All other ops: jump=0, target=pc+4.
- Broadcast: head fields are driven combinationally. A pop occurs when alu_valid=1 at a posedge. Unpopped entries stay until granted, in FIFO order, with no reordering.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal even at count=DEPTH.
- Pointers wrap modulo DEPTH.
- Push with count=DEPTH and no pop is a protocol violation: the op is dropped, state is unchanged, and alu_ovf_err is set. The flag clears only on reset.
- Flush (wrong_commit=1 with rdy=1): count and pointers are set to 0 and any same-cycle issue is discarded.
  - The same-cycle pop is still considered complete; the broadcast was already visible.
  - Flush takes priority over push.
- Reset also has priority over everything, including mid-stream; a result in flight is lost.

Test Plan:
- ADD, Vi=5, Vj=7, tag 3, grant held 1: the next cycle shows alu_valid=1, alu_res=12, alu_rob_id=3, alu_jump=0, alu_target=pc+4. The cycle after shows alu_valid=0.
- BLT, Vi=0xFFFFFFFF, Vj=1, pc=0x100, imm=0x20: res=0, jump=1, target=0x120. The same operands with BLTU give jump=0, target=0x104.
- JALR, Vi=0x1003, imm=4, pc=0x40: res=0x44, jump=1, target=0x1006. SRAI with Vi=0x80000000, imm=4 gives 0xF8000000.
- Grant held 0 while issuing tags 1,2,3:
  - alu_full rises once count reaches 3.
  - After grant goes to 1, tags broadcast 1,2,3 on consecutive cycles, and alu_full falls after the first pop.
- With 2 entries buffered, wrong_commit is asserted together with an issue: the next cycle shows cdb_req=0 and count=0; the dropped tag never appears.
- DEPTH entries buffered, grant=0, issue forced: alu_ovf_err=1 and the contents are unchanged. Then rst=0 for one cycle: all outputs read 0 and the error flag clears.
